// File: rtl/rdn_weight_stream_if.sv
// Bundle of the weight loader's memory handshake and per-layer weight buses.
// "master" is the loader side; "slave" is the memory/neuron environment.
interface rdn_weight_stream_if #(
  parameter int LINE_WORDS = 32,
  parameter int WORD_W     = 16,
  parameter int A_NEURONS  = 15,
  parameter int A_WEIGHTS  = 401,
  parameter int B_NEURONS  = 15,
  parameter int B_WEIGHTS  = 16,
  parameter int C_NEURONS  = 36,
  parameter int C_WEIGHTS  = 16
);
  localparam int A_SW  = (A_NEURONS > 1) ? $clog2(A_NEURONS) : 1;
  localparam int A_WSW = (A_WEIGHTS > 1) ? $clog2(A_WEIGHTS) : 1;
  localparam int B_SW  = (B_NEURONS > 1) ? $clog2(B_NEURONS) : 1;
  localparam int B_WSW = (B_WEIGHTS > 1) ? $clog2(B_WEIGHTS) : 1;
  localparam int C_SW  = (C_NEURONS > 1) ? $clog2(C_NEURONS) : 1;
  localparam int C_WSW = (C_WEIGHTS > 1) ? $clog2(C_WEIGHTS) : 1;

  logic                                 go;
  logic                                 mem_ready;
  logic [LINE_WORDS-1:0][WORD_W-1:0]    mem_data;
  logic                                 req_mem;

  logic signed [WORD_W-1:0]             a_weight_bus;
  logic signed [WORD_W-1:0]             b_weight_bus;
  logic signed [WORD_W-1:0]             c_weight_bus;
  logic [A_SW-1:0]                      a_sel;
  logic [B_SW-1:0]                      b_sel;
  logic [C_SW-1:0]                      c_sel;
  logic [A_WSW-1:0]                     a_weight_sel;
  logic [B_WSW-1:0]                     b_weight_sel;
  logic [C_WSW-1:0]                     c_weight_sel;
  logic                                 write_a;
  logic                                 write_b;
  logic                                 write_c;
  logic                                 weight_valid;

  modport master (
    input  go, mem_ready, mem_data,
    output req_mem,
    output a_weight_bus, b_weight_bus, c_weight_bus,
    output a_sel, b_sel, c_sel,
    output a_weight_sel, b_weight_sel, c_weight_sel,
    output write_a, write_b, write_c,
    output weight_valid
  );

  modport slave (
    output go, mem_ready, mem_data,
    input  req_mem,
    input  a_weight_bus, b_weight_bus, c_weight_bus,
    input  a_sel, b_sel, c_sel,
    input  a_weight_sel, b_weight_sel, c_weight_sel,
    input  write_a, write_b, write_c,
    input  weight_valid
  );
endinterface

// File: rtl/rdn_weight_stream.sv
// Streams a dense weight image (layer A, then B, then C) from line-wide memory
// reads into the neuron layers, one signed word per cycle, with registered outputs.
module rdn_weight_stream #(
  parameter int LINE_WORDS = 32,
  parameter int WORD_W     = 16,
  parameter int A_NEURONS  = 15,
  parameter int A_WEIGHTS  = 401,
  parameter int B_NEURONS  = 15,
  parameter int B_WEIGHTS  = 16,
  parameter int C_NEURONS  = 36,
  parameter int C_WEIGHTS  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  rdn_weight_stream_if.master bus
);

  function automatic int sw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  localparam int A_SW   = sw(A_NEURONS);
  localparam int A_WSW  = sw(A_WEIGHTS);
  localparam int B_SW   = sw(B_NEURONS);
  localparam int B_WSW  = sw(B_WEIGHTS);
  localparam int C_SW   = sw(C_NEURONS);
  localparam int C_WSW  = sw(C_WEIGHTS);
  localparam int NEU_W  = max3(A_SW, B_SW, C_SW);
  localparam int WGT_W  = max3(A_WSW, B_WSW, C_WSW);
  localparam int LW_SW  = sw(LINE_WORDS);
  localparam int TOTAL  = A_NEURONS * A_WEIGHTS + B_NEURONS * B_WEIGHTS + C_NEURONS * C_WEIGHTS;
  localparam int CNT_W  = sw(TOTAL);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WRITE, S_DONE} state_e;
  typedef enum logic [1:0] {L_A, L_B, L_C}                   layer_e;
  typedef logic [LINE_WORDS-1:0][WORD_W-1:0]                 line_t;

  state_e             state_q, state_d;
  layer_e             layer_q, layer_d;
  line_t              line_q,  line_d;
  logic [LW_SW-1:0]   word_q,  word_d;
  logic [NEU_W-1:0]   neu_q,   neu_d;
  logic [WGT_W-1:0]   wgt_q,   wgt_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  logic [NEU_W-1:0]   last_neu;
  logic [WGT_W-1:0]   last_wgt;

  logic               req_mem_q, req_mem_d;
  logic               weight_valid_q, weight_valid_d;
  logic               write_a_q, write_a_d;
  logic               write_b_q, write_b_d;
  logic               write_c_q, write_c_d;
  logic [WORD_W-1:0]  a_bus_q, a_bus_d;
  logic [WORD_W-1:0]  b_bus_q, b_bus_d;
  logic [WORD_W-1:0]  c_bus_q, c_bus_d;
  logic [A_SW-1:0]    a_sel_q, a_sel_d;
  logic [B_SW-1:0]    b_sel_q, b_sel_d;
  logic [C_SW-1:0]    c_sel_q, c_sel_d;
  logic [A_WSW-1:0]   a_wsel_q, a_wsel_d;
  logic [B_WSW-1:0]   b_wsel_q, b_wsel_d;
  logic [C_WSW-1:0]   c_wsel_q, c_wsel_d;
  logic [WORD_W-1:0]  word_val;
  logic               emit;

  // Geometry of the layer currently being loaded.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    last_neu = NEU_W'(A_NEURONS - 1);
    last_wgt = WGT_W'(A_WEIGHTS - 1);
    unique case (layer_q)
      L_B: begin
        last_neu = NEU_W'(B_NEURONS - 1);
        last_wgt = WGT_W'(B_WEIGHTS - 1);
      end
      L_C: begin
        last_neu = NEU_W'(C_NEURONS - 1);
        last_wgt = WGT_W'(C_WEIGHTS - 1);
      end
      default: ;
    endcase
  end

  // Next-state: the *_q pointers always name the word to be emitted in the current WRITE cycle.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    word_d  = word_q;
    layer_d = layer_q;
    neu_d   = neu_q;
    wgt_d   = wgt_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.go) begin
          state_d = S_REQ;
          layer_d = L_A;
          neu_d   = '0;
          wgt_d   = '0;
          cnt_d   = '0;
        end
      end

      S_REQ: begin
        if (bus.mem_ready) begin
          state_d = S_WRITE;
          line_d  = bus.mem_data;
          word_d  = '0;
        end
      end

      S_WRITE: begin
        cnt_d  = cnt_q + CNT_W'(1);
        word_d = word_q + LW_SW'(1);
        if (wgt_q == last_wgt) begin
          wgt_d = '0;
          if (neu_q == last_neu) begin
            neu_d = '0;
            unique case (layer_q)
              L_A:     layer_d = L_B;
              L_B:     layer_d = L_C;
              default: layer_d = L_A;
            endcase
          end else begin
            neu_d = neu_q + NEU_W'(1);
          end
        end else begin
          wgt_d = wgt_q + WGT_W'(1);
        end

        if (cnt_q == CNT_W'(TOTAL - 1)) begin
          state_d = S_DONE;
        end else if (word_q == LW_SW'(LINE_WORDS - 1)) begin
          state_d = S_REQ;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from next-state so every port is a flop.
  always_comb begin
    emit           = (state_d == S_WRITE);
    word_val       = line_d[word_d];
    req_mem_d      = (state_d == S_REQ);
    weight_valid_d = (state_d == S_DONE);

    write_a_d = emit && (layer_d == L_A);
    write_b_d = emit && (layer_d == L_B);
    write_c_d = emit && (layer_d == L_C);

    a_bus_d  = write_a_d ? word_val : '0;
    b_bus_d  = write_b_d ? word_val : '0;
    c_bus_d  = write_c_d ? word_val : '0;
    a_sel_d  = write_a_d ? neu_d[A_SW-1:0]  : '0;
    b_sel_d  = write_b_d ? neu_d[B_SW-1:0]  : '0;
    c_sel_d  = write_c_d ? neu_d[C_SW-1:0]  : '0;
    a_wsel_d = write_a_d ? wgt_d[A_WSW-1:0] : '0;
    b_wsel_d = write_b_d ? wgt_d[B_WSW-1:0] : '0;
    c_wsel_d = write_c_d ? wgt_d[C_WSW-1:0] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      layer_q <= L_A;
      // NOTE: the line register is reset too, so a reset leaves no stale weights that a later read could expose.
      line_q  <= '0;
      word_q  <= '0;
      neu_q   <= '0;
      wgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      layer_q <= layer_d;
      line_q  <= line_d;
      word_q  <= word_d;
      neu_q   <= neu_d;
      wgt_q   <= wgt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_mem_q      <= 1'b0;
      weight_valid_q <= 1'b0;
      write_a_q      <= 1'b0;
      write_b_q      <= 1'b0;
      write_c_q      <= 1'b0;
      a_bus_q        <= '0;
      b_bus_q        <= '0;
      c_bus_q        <= '0;
      a_sel_q        <= '0;
      b_sel_q        <= '0;
      c_sel_q        <= '0;
      a_wsel_q       <= '0;
      b_wsel_q       <= '0;
      c_wsel_q       <= '0;
    end else begin
      req_mem_q      <= req_mem_d;
      weight_valid_q <= weight_valid_d;
      write_a_q      <= write_a_d;
      write_b_q      <= write_b_d;
      write_c_q      <= write_c_d;
      a_bus_q        <= a_bus_d;
      b_bus_q        <= b_bus_d;
      c_bus_q        <= c_bus_d;
      a_sel_q        <= a_sel_d;
      b_sel_q        <= b_sel_d;
      c_sel_q        <= c_sel_d;
      a_wsel_q       <= a_wsel_d;
      b_wsel_q       <= b_wsel_d;
      c_wsel_q       <= c_wsel_d;
    end
  end

  assign bus.req_mem      = req_mem_q;
  assign bus.weight_valid = weight_valid_q;
  assign bus.write_a      = write_a_q;
  assign bus.write_b      = write_b_q;
  assign bus.write_c      = write_c_q;
  assign bus.a_weight_bus = a_bus_q;
  assign bus.b_weight_bus = b_bus_q;
  assign bus.c_weight_bus = c_bus_q;
  assign bus.a_sel        = a_sel_q;
  assign bus.b_sel        = b_sel_q;
  assign bus.c_sel        = c_sel_q;
  assign bus.a_weight_sel = a_wsel_q;
  assign bus.b_weight_sel = b_wsel_q;
  assign bus.c_weight_sel = c_wsel_q;

endmodule

// File: tb/tb_rdn_weight_stream.sv
// Randomized scoreboard bench for rdn_weight_stream at the default network geometry:
// a memory responder with random stalls, an image-order reference model and a write monitor.
module tb_rdn_weight_stream;

  localparam int LW    = 32;
  localparam int WW    = 16;
  localparam int AN    = 15;
  localparam int AW    = 401;
  localparam int BN    = 15;
  localparam int BW    = 16;
  localparam int CN    = 36;
  localparam int CW    = 16;
  localparam int A_TOT = AN * AW;
  localparam int B_TOT = BN * BW;
  localparam int T     = A_TOT + B_TOT + CN * CW;
  localparam int LOAD_BUDGET = 12000;

  typedef struct {
    int          layer;
    int          sel;
    int          wsel;
    logic [WW-1:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rdn_weight_stream_if #(
    .LINE_WORDS(LW), .WORD_W(WW),
    .A_NEURONS(AN), .A_WEIGHTS(AW),
    .B_NEURONS(BN), .B_WEIGHTS(BW),
    .C_NEURONS(CN), .C_WEIGHTS(CW)
  ) wif ();

  rdn_weight_stream #(
    .LINE_WORDS(LW), .WORD_W(WW),
    .A_NEURONS(AN), .A_WEIGHTS(AW),
    .B_NEURONS(BN), .B_WEIGHTS(BW),
    .C_NEURONS(CN), .C_WEIGHTS(CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (wif)
  );

  int            checks = 0;
  int            errors = 0;
  exp_t          sb[$];
  logic [WW-1:0] image [T];
  int            line_no        = 0;
  int            force_stall    = -1;
  int            expect_req_run = 0;
  int            writes_seen    = 0;
  int            stall_cnt      = -1;

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic longint key(input int layer, input int sel, input int wsel, input logic [WW-1:0] d);
    return (longint'(layer) << 48) | (longint'(sel) << 32) | (longint'(wsel) << 16) | longint'(d);
  endfunction

  // {req_mem, weight_valid, any strobe, A lane nonzero, B lane nonzero, C lane nonzero}
  function automatic logic [5:0] out_flags();
    return {wif.req_mem, wif.weight_valid, wif.write_a | wif.write_b | wif.write_c,
            |{wif.a_weight_bus, wif.a_sel, wif.a_weight_sel},
            |{wif.b_weight_bus, wif.b_sel, wif.b_weight_sel},
            |{wif.c_weight_bus, wif.c_sel, wif.c_weight_sel}};
  endfunction

  // Reference: global word g maps to (layer, neuron, weight) by plain division of the image order.
  function automatic exp_t model(input int g);
    exp_t e;
    if (g < A_TOT) begin
      e.layer = 0; e.sel = g / AW; e.wsel = g % AW;
    end else if (g < A_TOT + B_TOT) begin
      e.layer = 1; e.sel = (g - A_TOT) / BW; e.wsel = (g - A_TOT) % BW;
    end else begin
      e.layer = 2; e.sel = (g - A_TOT - B_TOT) / CW; e.wsel = (g - A_TOT - B_TOT) % CW;
    end
    e.data = image[g];
    return e;
  endfunction

  // ---------------- memory responder ----------------
  initial begin
    wif.mem_ready = 1'b0;
    wif.mem_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      wif.mem_ready = 1'b0;
      if (!rst_n) begin
        stall_cnt = -1;
      end else if (wif.req_mem) begin
        if (stall_cnt < 0) begin
          stall_cnt   = (force_stall >= 0) ? force_stall : int'($urandom_range(0, 3));
          force_stall = -1;
        end
        if (stall_cnt == 0) begin
          for (int i = 0; i < LW; i++) begin
            int idx;
            idx = line_no * LW + i;
            wif.mem_data[i] = (idx < T) ? image[idx] : WW'($urandom);
          end
          line_no++;
          wif.mem_ready = 1'b1;
          stall_cnt     = -1;
        end else begin
          stall_cnt--;
        end
      end else if ($urandom_range(0, 5) == 0) begin
        for (int i = 0; i < LW; i++) wif.mem_data[i] = WW'($urandom);
        wif.mem_ready = 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int         nwr;
  int         line_left = 0;
  bit         burst_end = 0;
  int         req_run   = 0;
  exp_t       e_pop;
  int         act_layer, act_sel, act_wsel;
  logic [WW-1:0] act_data;
  logic [5:0] fl;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      line_left = 0;
      burst_end = 0;
      req_run   = 0;
    end else begin
      fl  = out_flags();
      nwr = int'(wif.write_a) + int'(wif.write_b) + int'(wif.write_c);
      if (nwr > 1) check("one_hot_strobes", nwr, 1);

      if (burst_end) begin
        burst_end = 0;
        if (sb.size() > 0) begin
          check("req_after_line", wif.req_mem, 1);
        end else begin
          check("valid_after_last_write", wif.weight_valid, 1);
          check("req_low_when_done", wif.req_mem, 0);
        end
      end

      if (line_left > 0) begin
        check("write_in_burst", nwr, 1);
        if (nwr == 1) begin
          if (wif.write_a) begin
            act_layer = 0; act_sel = int'(wif.a_sel); act_wsel = int'(wif.a_weight_sel); act_data = wif.a_weight_bus;
          end else if (wif.write_b) begin
            act_layer = 1; act_sel = int'(wif.b_sel); act_wsel = int'(wif.b_weight_sel); act_data = wif.b_weight_bus;
          end else begin
            act_layer = 2; act_sel = int'(wif.c_sel); act_wsel = int'(wif.c_weight_sel); act_data = wif.c_weight_bus;
          end
          e_pop = sb.pop_front();
          check("write_layer_sel_wsel_data", key(act_layer, act_sel, act_wsel, act_data),
                key(e_pop.layer, e_pop.sel, e_pop.wsel, e_pop.data));
          check("inactive_lanes_zero", fl[2:0] & ~{wif.write_a, wif.write_b, wif.write_c}, 0);
          check("req_valid_low_in_write", {wif.req_mem, wif.weight_valid}, 0);
          writes_seen++;
        end
        line_left--;
        if (line_left == 0) burst_end = 1;
      end else begin
        check("no_write_outside_burst", nwr, 0);
        check("lanes_zero_outside_burst", fl[2:0], 0);
      end

      if (wif.req_mem && wif.mem_ready) begin
        if (expect_req_run != 0) begin
          check("req_held_through_stall", req_run + 1, expect_req_run);
          expect_req_run = 0;
        end
        line_left = (sb.size() < LW) ? sb.size() : LW;
        req_run   = 0;
      end else if (wif.req_mem) begin
        req_run++;
      end else begin
        req_run = 0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic pulse_go();
    wif.go = 1'b1;
    @(posedge clk);
    #1;
    wif.go = 1'b0;
  endtask

  task automatic start_load();
    for (int g = 0; g < T; g++) image[g] = WW'($urandom);
    for (int g = 0; g < T; g++) sb.push_back(model(g));
    line_no     = 0;
    writes_seen = 0;
    @(posedge clk);
    #1;
    pulse_go();
    @(negedge clk);
    check("req_one_cycle_after_go", wif.req_mem, 1);
    check("valid_cleared_by_go", wif.weight_valid, 0);
  endtask

  task automatic wait_writes(input int n);
    int cyc;
    cyc = 0;
    while (writes_seen < n && cyc < LOAD_BUDGET) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("writes_reached_in_budget", (writes_seen >= n) ? 1 : 0, 1);
  endtask

  task automatic wait_done();
    int cyc;
    cyc = 0;
    while (!wif.weight_valid && cyc < LOAD_BUDGET) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("load_completes_in_budget", wif.weight_valid, 1);
    check("scoreboard_drained", sb.size(), 0);
    check("word_count", writes_seen, T);
  endtask

  initial begin
    wif.go = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("reset_outputs_zero", out_flags(), 0);

    // Load 1: first request stalled, then reset after 9 writes.
    force_stall    = 6;
    expect_req_run = 7;
    start_load();
    wait_writes(9);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs_zero", out_flags(), 0);
    check("async_reset_valid_low", wif.weight_valid, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_outputs_zero", out_flags(), 0);

    // Load 2: full load from IDLE after the aborted one.
    start_load();
    wait_done();
    repeat (5) @(negedge clk);
    check("valid_sticky_in_done", wif.weight_valid, 1);
    check("done_outputs_quiet", out_flags() & 6'b101111, 0);

    // Load 3: reload from DONE, with go pulses while busy.
    start_load();
    wait_writes(100);
    pulse_go();
    wait_writes(3000);
    pulse_go();
    begin
      int cyc;
      cyc = 0;
      while (!wif.req_mem && cyc < 200) begin
        @(negedge clk);
        #1;
        cyc++;
      end
      check("req_seen_for_go_in_req", wif.req_mem, 1);
    end
    pulse_go();
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "simulation timeout");
  end

endmodule

// File: doc/rdn_weight_stream.md
# rdn_weight_stream

Parametrised weight loader for the rotation-detection network. It fetches packed weight lines from memory over a request/ready handshake and streams one signed word per cycle into the A, B and C neuron layers. For each word it supplies the target layer, neuron index and weight index. Layer sizes, weights per neuron and memory line width are all parameters, so any network geometry can be loaded from one image. It also asserts a sticky `weight_valid` when loading completes and supports reloading on a later `go`.

## Interface
- `LINE_WORDS`, 32, words per memory line
- `WORD_W`, 16, weight word width (signed)
- `A_NEURONS`, 15, A-layer neuron count
- `A_WEIGHTS`, 401, words per A neuron; index 0 is bias
- `B_NEURONS`, 15, B-layer neuron count
- `B_WEIGHTS`, 16, words per B neuron; index 0 is bias
- `C_NEURONS`, 36, C-layer neuron count
- `C_WEIGHTS`, 16, words per C neuron; index 0 is bias
- Selector widths: `SW(N)` = max(1, $clog2(N))

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `go`  in  1  start a load; ignored unless in IDLE or DONE
- `mem_ready`  in  1  memory line valid this cycle
- `mem_data`  in  `[WORD_W-1:0]` x `[LINE_WORDS-1:0]`  line words; word 0 is first in stream order
- `req_mem`  out  1  line request
- `a_weight_bus`, `b_weight_bus`, `c_weight_bus`  out  `WORD_W` signed  per-layer weight word
- `a_sel` / `b_sel` / `c_sel`  out  SW of the neuron count  target neuron
- `a_weight_sel` / `b_weight_sel` / `c_weight_sel`  out  SW of the weights per neuron  target weight index
- `write_a`, `write_b`, `write_c`  out  1  write strobe, at most one high per cycle
- `weight_valid`  out  1  all weights loaded (sticky)

## Operation
- **Memory image:** dense and unpadded. Order is layer A, then B, then C. Within a layer, neurons ascend; within a neuron, weight index ascends from 0.
- **Total words:** T = A_N·A_W + B_N·B_W + C_N·C_W. Words left over in the last line after word T-1 are discarded.
- **IDLE:**
  - All outputs are 0.
  - `go` clears `weight_valid` and moves to REQ.
- **REQ:**
  - `req_mem`=1, held until `mem_ready`=1.
  - On that cycle the line is latched into an internal line register and the state moves to WRITE.
  - `mem_ready` while `req_mem`=0 is ignored.
- **WRITE:**
  - Each cycle, emit line word `w` on the current layer's bus.
  - Assert that layer's write strobe with the current neuron and weight selectors.
  - Advance the weight index. At `*_WEIGHTS`-1 it wraps to 0 and the neuron index increments. At the last neuron the index wraps to 0 and the layer advances A→B→C.
  - After global word T-1, go to DONE.
  - Otherwise, after line word `LINE_WORDS`-1, go to REQ.
- **DONE:**
  - `weight_valid`=1; all strobes and `req_mem` are 0.
  - `go` restarts from word 0, clears `weight_valid`, and moves to REQ.
- **Idle outputs:**
  - Inactive layers' buses and selectors hold 0.
  - With no write in progress, every bus, selector and strobe is 0.
- `go` in REQ or WRITE has no effect.
- **Reset, including mid-load:**
  - Immediately returns to IDLE.
  - Clears all counters, the line register and `weight_valid`.
  - All outputs 0; any partial load is abandoned.

## Timing
- All outputs are registered. Nothing is combinational from the inputs.
- `go` high at cycle 0 → `req_mem` high at cycle 1.
- `mem_ready` high at cycle k while `req_mem` is high → `req_mem` low at k+1, first write at k+1. Words then stream at one per cycle on k+1 … k+L, where L = min(`LINE_WORDS`, words remaining).
- The next `req_mem` rises at k+L+1.
- Throughput: one word per cycle within a line. Each line costs at least one request cycle.
- `weight_valid` rises the cycle after the final write strobe.

## Test plan
- **Small config, exact fill:**
  - Parameters `LINE_WORDS`=4, A 2×3, B 2×2, C 3×2, so T=16 (4 lines).
  - `mem_data` word = line·4 + index.
  - Strobe sequence: `write_a` ×6 with (sel, wsel) = (0,0)(0,1)(0,2)(1,0)(1,1)(1,2), data 0–5; `write_b` ×4, data 6–9; `write_c` ×6, data 10–15.
  - `weight_valid` high one cycle after data 15.
- **Partial last line:**
  - Same config but C 3×3, so T=19.
  - The fifth line supplies words 16–18; line word 3 is never written.
  - Exactly 5 `req_mem` handshakes.
- **Memory stall:**
  - `mem_ready` delayed 7 cycles.
  - `req_mem` stays high for 7 cycles.
  - No strobes until the cycle after `mem_ready`.
  - `mem_ready` pulses while `req_mem`=0 are ignored.
- **`go` while busy:**
  - Pulse `go` mid-WRITE.
  - Sequence and word count unchanged; `weight_valid` timing unchanged.
- **Reset mid-load, then reload:**
  - Drop `rst_n` after 9 writes.
  - All outputs 0 asynchronously and `weight_valid`=0.
  - A new `go` restarts at A neuron 0, weight 0, data from line 0.
- **Reload from DONE with defaults:**
  - Default parameters, T=6831 words (214 lines).
  - Final write is `write_c`, c_sel=35, c_weight_sel=15.
  - A second `go` drops `weight_valid` the next cycle and repeats the same sequence.
